// File: rtl/fft_avg_pkg.sv
// Shared types for the complex averaging front end.
// Sample packing, sequencer states and fixed pipeline lead/settle depths.
package fft_avg_pkg;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx16_t;

  typedef enum logic [2:0] {
    IDLE,
    FIRST,
    LOAD,
    RUN,
    SETTLE,
    HOLD
  } avg_state_e;

  localparam int LOAD_LEAD  = 2;
  localparam int SETTLE_CYC = 2;

endpackage

// File: rtl/avg_frame_sequencer.sv
// Feeds one averaging block into the accumulator and returns its result.
// Optional AVG_OVERRUN_CNT_EN adds ovr_cnt (starts ignored while busy).
module avg_frame_sequencer
  import fft_avg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  samp_num,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] acc_val,
  output logic              acc_ce,
  output logic              acc_load,
  output logic [CNT_W-1:0]  acc_samp,
  input  logic [DATA_W-1:0] acc_result,
  output logic [DATA_W-1:0] res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic              err
`ifdef AVG_OVERRUN_CNT_EN
  ,
  output logic [15:0]       ovr_cnt
`endif
);

  localparam logic [1:0] PH_LOAD   = 2'(LOAD_LEAD - 1);
  localparam logic [1:0] PH_SETTLE = 2'(SETTLE_CYC - 1);

  avg_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  samp_q, samp_d;
  logic [1:0]        ph_q, ph_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              ce_q, ce_d;
  logic              load_q, load_d;
  logic              rv_q, rv_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      samp_q  <= '0;
      ph_q    <= '0;
      val_q   <= '0;
      res_q   <= '0;
      ce_q    <= 1'b0;
      load_q  <= 1'b0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      samp_q  <= samp_d;
      ph_q    <= ph_d;
      val_q   <= val_d;
      res_q   <= res_d;
      ce_q    <= ce_d;
      load_q  <= load_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    samp_d  = samp_q;
    ph_d    = ph_q;
    val_d   = val_q;
    res_d   = res_q;
    ce_d    = 1'b0;
    load_d  = 1'b0;
    rv_d    = rv_q;
    err_d   = 1'b0;
    s_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (samp_num == '0) begin
            err_d = 1'b1;
          end else begin
            samp_d  = samp_num;
            cnt_d   = '0;
            state_d = FIRST;
          end
        end
      end
      FIRST: begin
        s_ready = 1'b1;
        if (s_valid) begin
          val_d   = s_data;
          load_d  = 1'b1;
          cnt_d   = CNT_W'(1);
          ph_d    = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        ph_d = ph_q + 2'd1;
        if (ph_q == PH_LOAD) begin
          ph_d    = '0;
          state_d = (cnt_q == samp_q) ? SETTLE : RUN;
        end
      end
      RUN: begin
        s_ready = 1'b1;
        if (s_valid) begin
          val_d = s_data;
          ce_d  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q + CNT_W'(1) == samp_q) begin
            ph_d    = '0;
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        ph_d = ph_q + 2'd1;
        // Last acc_ce lands in the first cycle; the result is stable by the second.
        if (ph_q == PH_SETTLE) begin
          ph_d    = '0;
          res_d   = acc_result;
          rv_d    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign acc_val   = val_q;
  assign acc_ce    = ce_q;
  assign acc_load  = load_q;
  assign acc_samp  = samp_q;
  assign res_data  = res_q;
  assign res_valid = rv_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);

`ifdef AVG_OVERRUN_CNT_EN
  logic [15:0] ovr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_q <= '0;
    end else if (start && state_q != IDLE && ovr_q != 16'hFFFF) begin
      ovr_q <= ovr_q + 16'd1;
    end
  end

  assign ovr_cnt = ovr_q;
`endif

endmodule

// File: tb/tb_avg_frame_sequencer.sv
// Bench for avg_frame_sequencer with a behavioural accumulator downstream.
// Build with AVG_OVERRUN_CNT_EN to also check ovr_cnt.
module tb_avg_frame_sequencer;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  samp_num;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] acc_val;
  logic              acc_ce;
  logic              acc_load;
  logic [CNT_W-1:0]  acc_samp;
  logic [DATA_W-1:0] acc_result;
  logic [DATA_W-1:0] res_data;
  logic              res_valid;
  logic              res_ready;
  logic              busy;
  logic              err;
`ifdef AVG_OVERRUN_CNT_EN
  logic [15:0]       ovr_cnt;
`endif

  avg_frame_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .samp_num   (samp_num),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .acc_val    (acc_val),
    .acc_ce     (acc_ce),
    .acc_load   (acc_load),
    .acc_samp   (acc_samp),
    .acc_result (acc_result),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .busy       (busy),
    .err        (err)
`ifdef AVG_OVERRUN_CNT_EN
    ,
    .ovr_cnt    (ovr_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic int clog2i(input int n);
    int s;
    s = 0;
    while ((1 << s) < n) s++;
    return s;
  endfunction

  // Accumulator stand-in: load lands two cycles after acc_load, ce adds.
  int   a_re, a_im;
  logic ld_d1;
  int   sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_re  <= 0;
      a_im  <= 0;
      ld_d1 <= 1'b0;
    end else begin
      ld_d1 <= acc_load;
      if (ld_d1) begin
        a_re <= int'($signed(acc_val[31:16]));
        a_im <= int'($signed(acc_val[15:0]));
      end else if (acc_ce) begin
        a_re <= a_re + int'($signed(acc_val[31:16]));
        a_im <= a_im + int'($signed(acc_val[15:0]));
      end
    end
  end

  always_comb begin
    sh = clog2i(int'(acc_samp));
    acc_result = {16'(a_re >>> sh), 16'(a_im >>> sh)};
  end

  int n_ce = 0;
  int n_ld = 0;

  always @(posedge clk) begin
    if (acc_ce) n_ce <= n_ce + 1;
    if (acc_load) n_ld <= n_ld + 1;
  end

  int n_pass = 0;
  int n_tot  = 0;
  logic [31:0] smp[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [31:0] ref_avg(input int n);
    int sr, si, k;
    sr = 0;
    si = 0;
    for (int i = 0; i < n; i++) begin
      sr += int'($signed(smp[i][31:16]));
      si += int'($signed(smp[i][15:0]));
    end
    k = clog2i(n);
    return {16'(sr >>> k), 16'(si >>> k)};
  endfunction

  // Runs one block up to HOLD; mode 0 = always valid, 1 = toggling, 2 = random.
  task automatic run_block(input int n, input int mode,
                           output logic [31:0] res, output int lat,
                           output int nce, output int nld);
    int   sent, cyc, ce0, ld0;
    logic hs;
    ce0 = n_ce;
    ld0 = n_ld;
    samp_num = CNT_W'(n);
    start = 1'b1;
    step();
    start = 1'b0;
    sent = 0;
    cyc = 0;
    while (sent < n && cyc < 300) begin
      case (mode)
        0: s_valid = 1'b1;
        1: s_valid = (cyc % 2 == 0);
        default: s_valid = ($urandom_range(0, 2) != 0);
      endcase
      s_data = smp[sent];
      hs = s_valid && s_ready;
      step();
      cyc++;
      if (hs) sent++;
    end
    s_valid = 1'b0;
    s_data = '0;
    while (!res_valid && cyc < 400) begin
      step();
      cyc++;
    end
    if (!res_valid) chk("res_valid_timeout", 32'(res_valid), 32'd1);
    lat = cyc;
    res = res_data;
    nce = n_ce - ce0;
    nld = n_ld - ld0;
  endtask

  task automatic release_hold();
    chk("hold_s_ready", 32'(s_ready), 32'd0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("released_valid", 32'(res_valid), 32'd0);
    chk("released_busy", 32'(busy), 32'd0);
  endtask

  typedef struct {
    int              n;
    int              mode;
    logic [7:0][31:0] s;
    logic [31:0]     exp;
    int              ece;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] res;
    int          lat, nce, nld, n;
    logic        ok;

    for (int i = 0; i < 8; i++) begin
      tbl[0].s[i] = 32'h0004_0008;
      tbl[1].s[i] = 32'hFFF0_0010;
      tbl[2].s[i] = {16'(2 * (i + 1)), 16'h0000};
      tbl[3].s[i] = (i % 2 == 0) ? 32'hFFFD_0001 : 32'hFFFC_0002;
    end
    tbl[0].n = 4; tbl[0].mode = 0; tbl[0].exp = 32'h0004_0008; tbl[0].ece = 3;
    tbl[1].n = 1; tbl[1].mode = 0; tbl[1].exp = 32'hFFF0_0010; tbl[1].ece = 0;
    tbl[2].n = 8; tbl[2].mode = 1; tbl[2].exp = 32'h0009_0000; tbl[2].ece = 7;
    tbl[3].n = 2; tbl[3].mode = 0; tbl[3].exp = 32'hFFFC_0001; tbl[3].ece = 1;

    rst = 1'b1;
    start = 1'b0;
    samp_num = '0;
    s_data = '0;
    s_valid = 1'b0;
    res_ready = 1'b0;
    #12;
    chk("rst_ctrl", {26'd0, s_ready, busy, acc_ce, acc_load, res_valid, err}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    rst = 1'b0;
    step();

    for (int k = 0; k < 4; k++) begin
      smp.delete();
      for (int i = 0; i < tbl[k].n; i++) smp.push_back(tbl[k].s[i]);
      run_block(tbl[k].n, tbl[k].mode, res, lat, nce, nld);
      chk($sformatf("vec%0d_res", k), res, tbl[k].exp);
      chk($sformatf("vec%0d_ce", k), 32'(nce), 32'(tbl[k].ece));
      chk($sformatf("vec%0d_load", k), 32'(nld), 32'd1);
      if (tbl[k].mode == 0)
        chk($sformatf("vec%0d_lat", k), 32'(lat), 32'(tbl[k].n + 4));
      release_hold();
    end

    for (int r = 0; r < 6; r++) begin
      n = 1 << $urandom_range(0, 5);
      smp.delete();
      for (int i = 0; i < n; i++) smp.push_back($urandom);
      run_block(n, 2, res, lat, nce, nld);
      chk($sformatf("rnd%0d_res", r), res, ref_avg(n));
      chk($sformatf("rnd%0d_ce", r), 32'(nce), 32'(n - 1));
      release_hold();
    end

    smp.delete();
    smp.push_back(32'h0010_0020);
    smp.push_back(32'h0030_0040);
    run_block(2, 0, res, lat, nce, nld);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      start = (i == 3 || i == 8 || i == 13);
      samp_num = 12'd4;
      step();
      start = 1'b0;
      if (!(res_valid && !s_ready && busy)) ok = 1'b0;
    end
    chk("hold_stable", 32'(ok), 32'd1);
    chk("hold_res", res_data, 32'h0020_0030);
`ifdef AVG_OVERRUN_CNT_EN
    chk("ovr_cnt3", 32'(ovr_cnt), 32'd3);
`endif
    start = 1'b1;
    res_ready = 1'b1;
    step();
    start = 1'b0;
    res_ready = 1'b0;
    chk("start_rr_valid", 32'(res_valid), 32'd0);
    step();
    chk("start_rr_busy", 32'(busy), 32'd0);
`ifdef AVG_OVERRUN_CNT_EN
    chk("ovr_cnt4", 32'(ovr_cnt), 32'd4);
`endif

    smp.delete();
    for (int i = 0; i < 16; i++) smp.push_back(32'h0100_0200 + 32'(i));
    samp_num = 12'd16;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 50 && n < 5; c++) begin
      s_valid = 1'b1;
      s_data = smp[n];
      ok = s_ready;
      step();
      if (ok) n++;
    end
    s_valid = 1'b0;
    chk("mid_run_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_ctrl", {26'd0, s_ready, busy, acc_ce, acc_load, res_valid, err}, 32'd0);
    chk("async_rst_val", acc_val, 32'd0);
    chk("async_rst_samp", 32'(acc_samp), 32'd0);
    step();
    rst = 1'b0;
    step();
    smp.delete();
    for (int i = 0; i < 4; i++) smp.push_back(32'h0008_FFF8 + 32'(i << 16));
    run_block(4, 0, res, lat, nce, nld);
    chk("post_rst_res", res, ref_avg(4));
    release_hold();

    n = n_ld;
    samp_num = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("err_pulse", {30'd0, err, busy}, 32'd2);
    step();
    chk("err_clear", {30'd0, err, busy}, 32'd0);
    chk("err_no_load", 32'(n_ld - n), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
